// File: rtl/ysyx_23060072_dmem_responder_pkg.sv
// Shared constants and types for the data-memory responder: FSM encodings,
// default base address and the captured-request record.
package ysyx_23060072_dmem_responder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } dmem_req_t;

endpackage

// File: rtl/ysyx_23060072_sram_array.sv
// Word-addressed storage, one 8-bit array per byte lane so each strobe bit
// gates its own lane; synchronous write, combinational read, never reset.
module ysyx_23060072_sram_array #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [31:0]                    wdata,
  input  logic [3:0]                     wstrb,
  output logic [31:0]                    rdata
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane [DEPTH_WORDS];

    always_ff @(posedge clk) begin
      if (we && wstrb[gi]) begin
        lane[addr] <= wdata[gi*8 +: 8];
      end
    end

    assign rdata[gi*8 +: 8] = lane[addr];
  end

endmodule

// File: rtl/ysyx_23060072_dmem_responder.sv
// Single-outstanding LSU data-memory responder with fixed request-to-response
// latency, range/alignment fault detection and byte-enabled stores.
module ysyx_23060072_dmem_responder
  import ysyx_23060072_dmem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_wstrb_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);
  localparam logic [3:0]  CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  logic [1:0]  state;
  logic [3:0]  cnt;
  dmem_req_t   req_q;
  dmem_req_t   in_req;
  dmem_req_t   cur;
  logic [31:0] rdata_q;
  logic        err_q;

  logic          accept;
  logic          to_resp;
  logic          cur_err;
  logic [AW-1:0] cur_idx;
  logic [31:0]   mem_rdata;
  logic          mem_we;

  assign req_ready_o = (state == ST_IDLE);
  assign accept      = req_valid_i & req_ready_o;

  // With LATENCY=1 the RESP transition happens on the accept edge itself, so
  // the live inputs stand in for the not-yet-captured request.
  assign in_req = {req_we_i, req_addr_i, req_wdata_i, req_wstrb_i};
  assign cur    = (state == ST_IDLE) ? in_req : req_q;

  assign cur_err = ({1'b0, cur.addr} < {1'b0, BASE_ADDR})
                 | ({1'b0, cur.addr} >= END_ADDR)
                 | (cur.addr[1:0] != 2'b00);
  assign cur_idx = AW'((cur.addr - BASE_ADDR) >> 2);

  assign to_resp = ((state == ST_IDLE) && accept && (LATENCY == 1))
                 || ((state == ST_WAIT) && (cnt == 4'd0));
  assign mem_we  = to_resp & cur.we & ~cur_err;

  ysyx_23060072_sram_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_sram (
    .clk  (clk),
    .we   (mem_we),
    .addr (cur_idx),
    .wdata(cur.wdata),
    .wstrb(cur.wstrb),
    .rdata(mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      req_q   <= '0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            req_q <= in_req;
            if (LATENCY == 1) begin
              state <= ST_RESP;
            end else begin
              state <= ST_WAIT;
              cnt   <= CNT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            state <= ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Response payload is frozen here and held untouched through RESP.
      if (to_resp) begin
        rdata_q <= (cur.we || cur_err) ? 32'd0 : mem_rdata;
        err_q   <= cur_err;
      end
    end
  end

  assign rsp_valid_o = (state == ST_RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_ysyx_23060072_dmem_responder.sv
// Directed bench for the dmem responder (DEPTH 1024, base 0x8000_0000, LATENCY 2).
module tb_ysyx_23060072_dmem_responder;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int tests_run;
  int tests_failed;

  ysyx_23060072_dmem_responder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_we_i   (req_we),
    .req_addr_i (req_addr),
    .req_wdata_i(req_wdata),
    .req_wstrb_i(req_wstrb),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata),
    .rsp_err_o  (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // One full transaction; inputs are scrambled right after accept to prove capture.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] wstrb, output logic [31:0] rdata,
                      output logic err, output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = wstrb;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check_eq("accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = 32'h8000_0004;
    req_wdata = 32'h5A5A_5A5A;
    req_wstrb = 4'hF;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    $display("[TB] %s addr=%08h wdata=%08h wstrb=%h -> rdata=%08h err=%0d lat=%0d",
             we ? "ST" : "LD", addr, wdata, wstrb, rdata, err, lat);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lt;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    req_wstrb = 4'd0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_rdata", rsp_rdata, 32'd0);
    check_eq("rst_rsp_err", 32'(rsp_err), 32'd0);

    // Full-word store then load
    xact(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, rd, er, lt);
    check_eq("st10_rdata", rd, 32'd0);
    check_eq("st10_err", 32'(er), 32'd0);
    check_eq("st10_lat", 32'(lt), 32'd2);
    xact(1'b0, 32'h8000_0010, 32'd0, 4'h0, rd, er, lt);
    check_eq("ld10_rdata", rd, 32'hDEAD_BEEF);
    check_eq("ld10_err", 32'(er), 32'd0);
    check_eq("ld10_lat", 32'(lt), 32'd2);

    // Partial-strobe merge
    xact(1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF, rd, er, lt);
    xact(1'b1, 32'h8000_0020, 32'h0000_AA00, 4'b0010, rd, er, lt);
    xact(1'b0, 32'h8000_0020, 32'd0, 4'h0, rd, er, lt);
    check_eq("merge_rdata", rd, 32'h1122_AA44);

    // Zero strobe is a no-op with a normal response
    xact(1'b1, 32'h8000_0020, 32'hFFFF_FFFF, 4'h0, rd, er, lt);
    check_eq("wstrb0_err", 32'(er), 32'd0);
    xact(1'b0, 32'h8000_0020, 32'd0, 4'h0, rd, er, lt);
    check_eq("wstrb0_keep", rd, 32'h1122_AA44);

    // Faulting loads
    xact(1'b0, 32'h7FFF_FFFC, 32'd0, 4'h0, rd, er, lt);
    check_eq("below_err", 32'(er), 32'd1);
    check_eq("below_rdata", rd, 32'd0);
    xact(1'b0, 32'h8000_1000, 32'd0, 4'h0, rd, er, lt);
    check_eq("above_err", 32'(er), 32'd1);
    check_eq("above_rdata", rd, 32'd0);
    xact(1'b0, 32'h8000_0002, 32'd0, 4'h0, rd, er, lt);
    check_eq("misalign_err", 32'(er), 32'd1);
    check_eq("misalign_rdata", rd, 32'd0);
    check_eq("misalign_lat", 32'(lt), 32'd2);

    // Faulting stores that would alias word 0x20 if the fault were ignored
    xact(1'b1, 32'h8000_0022, 32'hFFFF_FFFF, 4'hF, rd, er, lt);
    check_eq("st_misalign_err", 32'(er), 32'd1);
    xact(1'b1, 32'h8000_1020, 32'hFFFF_FFFF, 4'hF, rd, er, lt);
    check_eq("st_oob_err", 32'(er), 32'd1);
    xact(1'b0, 32'h8000_0020, 32'd0, 4'h0, rd, er, lt);
    check_eq("err_st_keep", rd, 32'h1122_AA44);

    // Last valid word
    xact(1'b1, 32'h8000_0FFC, 32'h0BAD_F00D, 4'hF, rd, er, lt);
    xact(1'b0, 32'h8000_0FFC, 32'd0, 4'h0, rd, er, lt);
    check_eq("last_err", 32'(er), 32'd0);
    check_eq("last_rdata", rd, 32'h0BAD_F00D);

    // Back-pressure: hold RESP 5 cycles while a second request waits
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h8000_0010;
    @(negedge clk);
    req_addr  = 32'h8000_0020;
    @(negedge clk);
    check_eq("bp_valid_lat2", 32'(rsp_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_valid", 32'(rsp_valid), 32'd1);
      check_eq("bp_rdata", rsp_rdata, 32'hDEAD_BEEF);
      check_eq("bp_err", 32'(rsp_err), 32'd0);
      check_eq("bp_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq("bp_after_hs_valid", 32'(rsp_valid), 32'd0);
    check_eq("bp_after_hs_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("bp2_wait_ready", 32'(req_ready), 32'd0);
    check_eq("bp2_wait_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check_eq("bp2_valid", 32'(rsp_valid), 32'd1);
    check_eq("bp2_rdata", rsp_rdata, 32'h1122_AA44);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    $display("[TB] backpressure sequence done");

    // Reset while a store sits in WAIT
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h8000_0010;
    req_wdata = 32'hCAFE_F00D;
    req_wstrb = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("rw_in_wait", 32'(req_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check_eq("rw_rst_valid", 32'(rsp_valid), 32'd0);
    check_eq("rw_rst_idle", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rw_rel_valid", 32'(rsp_valid), 32'd0);
    check_eq("rw_rel_rdata", rsp_rdata, 32'd0);
    $display("[TB] reset during WAIT issued");
    xact(1'b0, 32'h8000_0010, 32'd0, 4'h0, rd, er, lt);
    check_eq("rw_old_rdata", rd, 32'hDEAD_BEEF);
    check_eq("rw_old_err", 32'(er), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
